// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: registered RV32I ALU-control decode stage with valid/ready
// flow control. Maps {alu_op, funct7, funct3} to an ALU operation code at the
// input, flags illegal encodings, and carries a tag alongside each entry.
// One or two register stages (STAGES), synchronous flush, and a saturating
// counter of illegal entries delivered downstream.
//
// Optional feature macro: RV32M_EN (adds MUL/DIV/REM decode for R-type
// funct7 0000001; requires OP_W >= 5).
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   flush               synchronous flush of all valid bits
//   in_valid/in_ready   upstream handshake
//   alu_op/funct7/funct3, in_tag   request fields
//   out_valid/out_ready downstream handshake
//   out_operation, out_illegal, out_tag   decoded entry at the output
//   illegal_count       saturating count of illegal entries transferred
module alu_ctrl_stage #(
  parameter int OP_W   = 5,
  parameter int TAG_W  = 5,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [6:0]       funct7,
  input  logic [2:0]       funct3,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  out_operation,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      illegal_count
);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SLL  = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SRA  = 5'b00111;
  localparam logic [4:0] OP_SLT  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef RV32M_EN
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif

  if (OP_W < 4) begin : g_bad_opw
    $error("alu_ctrl_stage: OP_W must be at least 4");
  end
`ifdef RV32M_EN
  if (OP_W < 5) begin : g_bad_opw_m
    $error("alu_ctrl_stage: OP_W must be at least 5 with RV32M_EN");
  end
`endif
  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("alu_ctrl_stage: STAGES must be 1 or 2");
  end

  // Returns {illegal, code}; code is forced to zero for illegal encodings.
  function automatic logic [5:0] decode(input logic [1:0] op,
                                        input logic [6:0] f7,
                                        input logic [2:0] f3);
    logic [4:0] base;
    logic [4:0] code;
    logic       ill;
    case (f3)
      3'b000:  base = OP_ADD;
      3'b001:  base = OP_SLL;
      3'b010:  base = OP_SLT;
      3'b011:  base = OP_SLTU;
      3'b100:  base = OP_XOR;
      3'b101:  base = OP_SRL;
      3'b110:  base = OP_OR;
      default: base = OP_AND;
    endcase
    code = OP_ADD;
    ill  = 1'b0;
    case (op)
      2'b00: code = OP_ADD;
      2'b01: begin
        case (f3)
          3'b000, 3'b001: code = OP_SUB;
          3'b100, 3'b101: code = OP_SLT;
          3'b110, 3'b111: code = OP_SLTU;
          default:        ill  = 1'b1;
        endcase
      end
      2'b10: begin
        if (f7 == F7_BASE)                     code = base;
        else if (f7 == F7_ALT && f3 == 3'b000) code = OP_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) code = OP_SRA;
`ifdef RV32M_EN
        else if (f7 == F7_MULDIV)              code = {2'b10, f3};
`endif
        else                                   ill  = 1'b1;
      end
      default: begin
        // I-type: funct7 only matters for the shift encodings.
        if (f3 == 3'b001) begin
          if (f7 == F7_BASE) code = OP_SLL;
          else               ill  = 1'b1;
        end else if (f3 == 3'b101) begin
          if (f7 == F7_BASE)     code = OP_SRL;
          else if (f7 == F7_ALT) code = OP_SRA;
          else                   ill  = 1'b1;
        end else begin
          code = base;
        end
      end
    endcase
    if (ill) code = '0;
    return {ill, code};
  endfunction

  logic [5:0]      dec_word;
  logic [OP_W-1:0] dec_op;
  logic            dec_illegal;
  logic            accept;

  assign dec_word    = decode(alu_op, funct7, funct3);
  assign dec_illegal = dec_word[5];
  assign dec_op      = OP_W'(dec_word[4:0]);
  // A request accepted during flush is dropped, so it never loads.
  assign accept      = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_count <= '0;
    end else if (out_valid && out_ready && out_illegal &&
                 illegal_count != 16'hFFFF) begin
      illegal_count <= illegal_count + 16'd1;
    end
  end

  if (STAGES == 1) begin : g_one
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid     <= 1'b0;
        out_operation <= '0;
        out_illegal   <= 1'b0;
        out_tag       <= '0;
      end else if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid     <= 1'b1;
        out_operation <= dec_op;
        out_illegal   <= dec_illegal;
        out_tag       <= in_tag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end else begin : g_two
    logic             s1_valid;
    logic [OP_W-1:0]  s1_op;
    logic             s1_illegal;
    logic [TAG_W-1:0] s1_tag;
    logic             advance;

    assign advance  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || advance;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid   <= 1'b0;
        s1_op      <= '0;
        s1_illegal <= 1'b0;
        s1_tag     <= '0;
      end else if (flush) begin
        s1_valid <= 1'b0;
      end else if (accept) begin
        s1_valid   <= 1'b1;
        s1_op      <= dec_op;
        s1_illegal <= dec_illegal;
        s1_tag     <= in_tag;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid     <= 1'b0;
        out_operation <= '0;
        out_illegal   <= 1'b0;
        out_tag       <= '0;
      end else if (flush) begin
        out_valid <= 1'b0;
      end else if (advance) begin
        out_valid     <= 1'b1;
        out_operation <= s1_op;
        out_illegal   <= s1_illegal;
        out_tag       <= s1_tag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Testbench for alu_ctrl_stage: one STAGES=1 and one STAGES=2 instance share
// the same inputs; each is checked against a queue-style reference model.
module tb_alu_ctrl_stage;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [1:0] alu_op;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] in_tag;
  logic       out_ready;

  logic        rdy  [2];
  logic        ov   [2];
  logic [4:0]  oop  [2];
  logic        oill [2];
  logic [4:0]  otag [2];
  logic [15:0] ocnt [2];

  int errors = 0;
  int checks = 0;

  // Reference model: per instance, the ordered entries held in the block.
  int m_n    [2];
  int m_op   [2][2];
  bit m_ill  [2][2];
  int m_tag  [2][2];
  int m_age  [2][2];
  int m_cnt  [2];
  int stg    [2] = '{1, 2};

  alu_ctrl_stage #(.OP_W(5), .TAG_W(5), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(rdy[0]), .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
    .in_tag(in_tag), .out_valid(ov[0]), .out_ready(out_ready),
    .out_operation(oop[0]), .out_illegal(oill[0]), .out_tag(otag[0]),
    .illegal_count(ocnt[0]));

  alu_ctrl_stage #(.OP_W(5), .TAG_W(5), .STAGES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(rdy[1]), .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
    .in_tag(in_tag), .out_valid(ov[1]), .out_ready(out_ready),
    .out_operation(oop[1]), .out_illegal(oill[1]), .out_tag(otag[1]),
    .illegal_count(ocnt[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoding rules as a table lookup; -1 means illegal.
  function automatic int ref_code(input logic [1:0] a, input logic [6:0] f7,
                                  input logic [2:0] f3);
    int base [8] = '{2, 3, 8, 9, 4, 5, 1, 0};
    if (a == 2'd0) return 2;
    if (a == 2'd1) begin
      if (f3 == 3'd0 || f3 == 3'd1) return 6;
      if (f3 == 3'd4 || f3 == 3'd5) return 8;
      if (f3 == 3'd6 || f3 == 3'd7) return 9;
      return -1;
    end
    if (a == 2'd2) begin
      if (f7 == 7'h00) return base[f3];
      if (f7 == 7'h20 && f3 == 3'd0) return 6;
      if (f7 == 7'h20 && f3 == 3'd5) return 7;
`ifdef RV32M_EN
      if (f7 == 7'h01) return 16 + int'(f3);
`endif
      return -1;
    end
    if (f3 == 3'd1) return (f7 == 7'h00) ? 3 : -1;
    if (f3 == 3'd5) return (f7 == 7'h00) ? 5 : ((f7 == 7'h20) ? 7 : -1);
    return base[f3];
  endfunction

  function automatic bit m_valid(input int i);
    return m_n[i] > 0 && m_age[i][0] >= stg[i];
  endfunction

  function automatic bit m_ready(input int i);
    return m_n[i] < stg[i] || out_ready;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_n[i]   = 0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] a, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [4:0] t,
                       input bit ordy, input bit fl);
    in_valid  = v;
    alu_op    = a;
    funct7    = f7;
    funct3    = f3;
    in_tag    = t;
    out_ready = ordy;
    flush     = fl;
  endtask

  // One clock: update the model from the inputs seen at the rising edge,
  // then return at the falling edge where outputs are sampled.
  task automatic tick();
    bit v [2];
    bit r [2];
    int code;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      v[i] = m_valid(i);
      r[i] = m_ready(i);
    end
    for (int i = 0; i < 2; i++) begin
      if (v[i] && out_ready) begin
        if (m_ill[i][0] && m_cnt[i] < 65535) m_cnt[i]++;
        m_op[i][0]  = m_op[i][1];
        m_ill[i][0] = m_ill[i][1];
        m_tag[i][0] = m_tag[i][1];
        m_age[i][0] = m_age[i][1];
        m_n[i]--;
      end
      if (flush) begin
        m_n[i] = 0;
      end else if (in_valid && r[i]) begin
        code = ref_code(alu_op, funct7, funct3);
        m_op[i][m_n[i]]  = (code < 0) ? 0 : code;
        m_ill[i][m_n[i]] = (code < 0);
        m_tag[i][m_n[i]] = int'(in_tag);
        m_age[i][m_n[i]] = 0;
        m_n[i]++;
      end
      for (int k = 0; k < m_n[i]; k++) m_age[i][k]++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 2'd0, 7'd0, 3'd0, 5'd0, 1, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 2'd0, 7'd0, 3'd0, 5'd0, 1, 0);
    model_reset();
    #3;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || oop[i] !== 5'd0 || oill[i] !== 1'b0 ||
          otag[i] !== 5'd0 || ocnt[i] !== 16'd0) begin
        errors++;
        $display("FAIL reset_values[%0d]: got v=%b op=%h ill=%b tag=%h cnt=%h required all zero",
                 i, ov[i], oop[i], oill[i], otag[i], ocnt[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready[%0d]: got %b required 1", i, rdy[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 2'd0, 7'd0, 3'd0, 5'd0, 1, 0);
    tick(); tick();
    drive(1, 2'b10, 7'h20, 3'b000, 5'd3, 1, 0);
    tick();
    checks++;
    if (ov[0] !== 1'b1 || oop[0] !== 5'b00110 || otag[0] !== 5'd3) begin
      errors++;
      $display("FAIL b2b_sub: got v=%b op=%b tag=%0d required v=1 op=00110 tag=3", ov[0], oop[0], otag[0]);
    end
    drive(1, 2'b11, 7'h20, 3'b101, 5'd4, 1, 0);
    tick();
    checks++;
    if (ov[0] !== 1'b1 || oop[0] !== 5'b00111 || otag[0] !== 5'd4) begin
      errors++;
      $display("FAIL b2b_sra: got v=%b op=%b tag=%0d required v=1 op=00111 tag=4", ov[0], oop[0], otag[0]);
    end
    drive(0, 2'd0, 7'd0, 3'd0, 5'd0, 1, 0);
    tick(); tick();
  endtask

  task automatic test_stall();
    drive(1, 2'b00, 7'h00, 3'b000, 5'd1, 0, 0);   // ADD
    tick();
    drive(1, 2'b10, 7'h00, 3'b110, 5'd2, 0, 0);   // OR
    tick();
    drive(1, 2'b10, 7'h00, 3'b111, 5'd3, 0, 0);   // AND
    #1;
    checks++;
    if (rdy[1] !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready: got %b required 0", rdy[1]);
    end
    tick();
    tick();
    checks++;
    if (ov[1] !== 1'b1 || oop[1] !== 5'b00010 || otag[1] !== 5'd1) begin
      errors++;
      $display("FAIL stall_hold: got v=%b op=%b tag=%0d required v=1 op=00010 tag=1", ov[1], oop[1], otag[1]);
    end
    drive(1, 2'b10, 7'h00, 3'b111, 5'd3, 1, 0);
    tick();
    checks++;
    if (ov[1] !== 1'b1 || oop[1] !== 5'b00001 || otag[1] !== 5'd2) begin
      errors++;
      $display("FAIL stall_second: got v=%b op=%b tag=%0d required v=1 op=00001 tag=2", ov[1], oop[1], otag[1]);
    end
    drive(0, 2'd0, 7'd0, 3'd0, 5'd0, 1, 0);
    tick();
    checks++;
    if (ov[1] !== 1'b1 || oop[1] !== 5'b00000 || otag[1] !== 5'd3) begin
      errors++;
      $display("FAIL stall_third: got v=%b op=%b tag=%0d required v=1 op=00000 tag=3", ov[1], oop[1], otag[1]);
    end
    tick();
    checks++;
    if (ov[1] !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: got v=%b required 0", ov[1]);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(1, 2'b01, 7'h00, 3'b010, 5'd7, 1, 0);
    tick();
    checks++;
    if (ov[0] !== 1'b1 || oill[0] !== 1'b1 || oop[0] !== 5'd0) begin
      errors++;
      $display("FAIL illegal_branch: got v=%b ill=%b op=%b required 1 1 00000", ov[0], oill[0], oop[0]);
    end
`ifdef RV32M_EN
    drive(1, 2'b10, 7'h7f, 3'b000, 5'd8, 1, 0);
`else
    drive(1, 2'b10, 7'h01, 3'b000, 5'd8, 1, 0);
`endif
    tick();
    checks++;
    if (ov[0] !== 1'b1 || oill[0] !== 1'b1 || oop[0] !== 5'd0) begin
      errors++;
      $display("FAIL illegal_rtype: got v=%b ill=%b op=%b required 1 1 00000", ov[0], oill[0], oop[0]);
    end
    drive(1, 2'b11, 7'h20, 3'b001, 5'd9, 1, 0);
    tick();
    checks++;
    if (ov[0] !== 1'b1 || oill[0] !== 1'b1 || oop[0] !== 5'd0) begin
      errors++;
      $display("FAIL illegal_itype: got v=%b ill=%b op=%b required 1 1 00000", ov[0], oill[0], oop[0]);
    end
    drive(0, 2'd0, 7'd0, 3'd0, 5'd0, 1, 0);
    tick();
    checks++;
    if (ocnt[0] !== 16'd3) begin
      errors++;
      $display("FAIL illegal_count_s1: got %0d required 3", ocnt[0]);
    end
    tick();
    checks++;
    if (ocnt[1] !== 16'd3) begin
      errors++;
      $display("FAIL illegal_count_s2: got %0d required 3", ocnt[1]);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 2'b00, 7'h00, 3'b000, 5'd2, 0, 0);
    tick();
    drive(0, 2'd0, 7'd0, 3'd0, 5'd0, 0, 0);
    tick();
    checks++;
    if (ov[0] !== 1'b1 || ov[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_held: got %b%b required 11", ov[0], ov[1]);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || ocnt[i] !== 16'd0) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got v=%b cnt=%0d required v=0 cnt=0", i, ov[i], ocnt[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 2'd0, 7'd0, 3'd0, 5'd0, 1, 0);
    #1;
    checks++;
    if (rdy[0] !== 1'b1 || rdy[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: got %b%b required 11", rdy[0], rdy[1]);
    end
  endtask

  task automatic test_flush();
    drive(1, 2'b01, 7'h00, 3'b011, 5'd5, 0, 0);
    tick();
    drive(1, 2'b01, 7'h00, 3'b010, 5'd6, 0, 0);
    tick();
    checks++;
    if (ov[1] !== 1'b1 || rdy[1] !== 1'b0) begin
      errors++;
      $display("FAIL flush_fill: got v=%b rdy=%b required v=1 rdy=0", ov[1], rdy[1]);
    end
    drive(1, 2'b00, 7'h00, 3'b000, 5'd7, 0, 1);
    tick();
    drive(0, 2'd0, 7'd0, 3'd0, 5'd0, 1, 0);
    checks++;
    if (ov[0] !== 1'b0 || ov[1] !== 1'b0 || ocnt[1] !== 16'd0) begin
      errors++;
      $display("FAIL flush_clear: got v=%b%b cnt=%0d required v=00 cnt=0", ov[0], ov[1], ocnt[1]);
    end
    tick(); tick();
    checks++;
    if (ov[1] !== 1'b0) begin
      errors++;
      $display("FAIL flush_dropped: got v=%b required 0", ov[1]);
    end
    drive(1, 2'b01, 7'h00, 3'b010, 5'd9, 1, 0);
    tick();
    drive(0, 2'd0, 7'd0, 3'd0, 5'd0, 1, 1);
    tick();
    drive(0, 2'd0, 7'd0, 3'd0, 5'd0, 1, 0);
    checks++;
    if (ocnt[0] !== 16'd1 || ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL flush_xfer_counts: got cnt=%0d v=%b required cnt=1 v=0", ocnt[0], ov[0]);
    end
    tick(); tick();
  endtask

  task automatic test_random();
    logic [6:0] f7;
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), f7,
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rdy[i] !== m_ready(i)) begin
          errors++;
          $display("FAIL rand_ready[%0d] cycle %0d: got %b required %b", i, n, rdy[i], m_ready(i));
        end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ov[i] !== m_valid(i)) begin
          errors++;
          $display("FAIL rand_valid[%0d] cycle %0d: got %b required %b", i, n, ov[i], m_valid(i));
        end else if (m_valid(i) &&
                     (int'(oop[i]) != m_op[i][0] || oill[i] !== m_ill[i][0] ||
                      int'(otag[i]) != m_tag[i][0])) begin
          errors++;
          $display("FAIL rand_data[%0d] cycle %0d: got op=%0d ill=%b tag=%0d required op=%0d ill=%b tag=%0d",
                   i, n, oop[i], oill[i], otag[i], m_op[i][0], m_ill[i][0], m_tag[i][0]);
        end
        checks++;
        if (int'(ocnt[i]) != m_cnt[i]) begin
          errors++;
          $display("FAIL rand_count[%0d] cycle %0d: got %0d required %0d", i, n, ocnt[i], m_cnt[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 2'b01, 7'h00, 3'b010, 5'd1, 1, 0);
    repeat (65535) tick();
    checks++;
    if (ocnt[0] !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_before: got %h required fffe", ocnt[0]);
    end
    repeat (3) tick();
    checks++;
    if (ocnt[0] !== 16'hFFFF || m_cnt[0] != 65535) begin
      errors++;
      $display("FAIL sat_hold: got %h model %0d required ffff", ocnt[0], m_cnt[0]);
    end
    drive(0, 2'd0, 7'd0, 3'd0, 5'd0, 1, 0);
    tick(); tick();
  endtask

`ifdef RV32M_EN
  task automatic test_rv32m();
    drive(1, 2'b10, 7'h01, 3'b101, 5'd11, 1, 0);
    tick();
    checks++;
    if (ov[0] !== 1'b1 || oop[0] !== 5'b10101 || oill[0] !== 1'b0) begin
      errors++;
      $display("FAIL m_divu: got v=%b op=%b ill=%b required 1 10101 0", ov[0], oop[0], oill[0]);
    end
    drive(0, 2'd0, 7'd0, 3'd0, 5'd0, 1, 0);
    tick(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_flush();
    test_random();
    test_saturation();
`ifdef RV32M_EN
    test_rv32m();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
